seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised multiplexed 7-segment scan driver for the board display, common-anode, active-low.
- Per-digit hex decode or raw segment pattern, decimal point, blanking, blinking and global PWM brightness.
- Frame-coherent input snapshot.
- Sits between application logic (counters, FSM state words) and the Indicators/Segments pins.

Parameters:
- Digits, 8, number of multiplexed digits (2..16).
- ClockPeriod_ns, 20, Clock period.
- RefreshTime_ns, 1_000_000, full-scan period target.
- DimBits, 3, brightness resolution; 2**DimBits duty steps.
- BlinkFrames, 250, frames per blink half-period.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Nibbles  in  Digits*4  hex value per digit; digit i = [4i+3:4i].
- RawSeg  in  Digits*8  raw active-low pattern per digit; digit i = [8i+7:8i].
- RawMode  in  Digits  1 = digit i shows RawSeg, 0 = hex-decoded Nibbles.
- Dp  in  Digits  1 = light decimal point of digit i (forces bit 7 low).
- Blank  in  Digits  1 = digit i dark.
- Blink  in  Digits  1 = digit i dark during blink-off phase.
- Brightness  in  DimBits  duty select; 0 = dimmest, all-ones = full.
- Indicators  out  Digits  active-low digit select; one-hot-low or all-ones.
- Segments  out  8  active-low {dp,g,f,e,d,c,b,a}.
- FrameStart  out  1  one-Clock pulse when the snapshot is taken.

Behaviour:
- Derived constants:
  - Prescale = RefreshTime_ns/ClockPeriod_ns/Digits.
  - SubPrescale = Prescale >> DimBits.
  - Slot = SubPrescale << DimBits Clocks.
  - Elaboration $error if SubPrescale < 1.
- Timebase: SelectNPulse with N=SubPrescale gives Tick, one Clock every SubPrescale Clocks.
- SubPhase (DimBits wide) increments on Tick.
- Digit counter DigitIdx advances only on the Tick where SubPhase wraps from all-ones to 0.
- Scan order: DigitIdx counts down Digits-1 to 0, then wraps to Digits-1.
- Frame boundary: on the advance where DigitIdx wraps to Digits-1:
  - all inputs are copied into snapshot registers;
  - FrameStart pulses in that same Clock.
- Displayed content comes only from the snapshot, so mid-frame input changes never tear a scan.
- Blink: a frame counter counts snapshots modulo BlinkFrames; BlinkOff toggles at each wrap.
- Output pipeline, registered, 1 Clock after any DigitIdx or SubPhase change:
  - Lit = ~Blank[d] & ~(Blink[d] & BlinkOff) & (SubPhase <= Brightness), all from the snapshot.
  - Pattern = RawMode[d] ? RawSeg[d] : hex(Nibbles[d]), with bit 7 cleared if Dp[d].
  - Lit: Indicators = ~(1 << DigitIdx), Segments = Pattern.
  - Not lit: Indicators = all ones, Segments = 8'hFF.
- Hex table, active-low: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Duty = (Brightness+1)/2**DimBits of each slot.
- Ghosting: Indicators is never multi-hot. Digit and pattern change in the same Clock, registered together.
- Reset state, asynchronous; registered outputs hold these values until Reset deasserts:
  - Indicators all ones, Segments 8'hFF, FrameStart 0;
  - DigitIdx = Digits-1, SubPhase = 0, BlinkOff = 0;
  - snapshot cleared: Blank all ones, so the display is dark;
  - prescaler cleared.
- First snapshot: taken at the first frame boundary after release, i.e. after one full scan of dark slots.
- Reset mid-frame: immediate return to the reset state; no partial frame completes.
- Brightness change mid-frame takes effect at the next FrameStart; it is part of the snapshot.
- Blank and Blink both set on a digit: dark in both blink phases (Blank dominates).

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK = 8'hFF;
  - the hex decode as a function hex7(logic [3:0]) returning active-low logic [7:0];
  - the DP bit index constant.
- Sub-module: reuse the existing SelectNPulse as the Tick prescaler; no other sub-module.
- Snapshot, blink and scan logic stay in seg_scan_driver.

Test Plan:
- Setup for all cases: Digits=4, DimBits=2, ClockPeriod_ns=20, RefreshTime_ns=1280, which gives Prescale=16, SubPrescale=4, Slot=16 Clocks.
- Reset and scan order:
  - Stimulus: hold Reset, then release with Nibbles=16'h1A3F, others 0, Brightness=3.
  - During Reset: Indicators=4'hF, Segments=FF.
  - After first FrameStart: Indicators 4'b0111, 1011, 1101, 1110 each for 16 Clocks, with Segments F9, 88, B0, 8E.
- Raw and decimal point:
  - Stimulus: RawMode=4'b0001, RawSeg[7:0]=8'hAA, Dp=4'b0010, Nibbles[7:4]=8.
  - Digit 0 shows AA; digit 1 shows 00.
- Brightness:
  - Stimulus: Brightness=0.
  - Each digit lit 4 of 16 Clocks; all-ones/FF for the remaining 12.
- Snapshot coherence:
  - Stimulus: change Nibbles mid-frame from 16'h1111 to 16'h2222.
  - Remaining digits of the current frame still show F9; new value A4 appears only after the next FrameStart.
- Blink and blank:
  - Stimulus: BlinkFrames=2, Blink=4'b0100, Blank=4'b1000.
  - Digit 3 always dark.
  - Digit 2 lit for 2 frames, dark for 2 frames, repeating.
- Async reset mid-slot:
  - Stimulus: assert Reset between Clock edges.
  - Indicators=F and Segments=FF immediately, with no Clock edge needed.
  - After release, DigitIdx restarts at 3.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment decode for the scan driver.
// Segment encoding is active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  // All segments dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Bit position of the decimal point inside a segment pattern.
  localparam int DP_BIT = 7;

  // Active-low 7-segment glyph for a hex digit; the dp bit is left dark.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/SelectNPulse.sv
// Free-running divide-by-N pulse generator: Pulse is high for one Clock
// out of every N. With N = 1 the pulse is permanently high.
module SelectNPulse #(
  parameter int N = 4
) (
  input  logic Clock,
  input  logic Reset,
  output logic Pulse
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  // Pulse is decoded straight from the counter so it lines up with the
  // Clock in which the count sits at its terminal value.
  assign Pulse = (count == LAST);

  // Count 0..N-1 and restart.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Pulse) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver, active-low outputs.
// Each digit owns a slot of 2**DimBits sub-phases; the digit is lit during
// the sub-phases not above Brightness. All displayed content comes from a
// snapshot taken once per frame, so input changes never tear a scan.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int Digits         = 8,
  parameter int ClockPeriod_ns = 20,
  parameter int RefreshTime_ns = 1_000_000,
  parameter int DimBits        = 3,
  parameter int BlinkFrames    = 250
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [Digits*4-1:0]   Nibbles,
  input  logic [Digits*8-1:0]   RawSeg,
  input  logic [Digits-1:0]     RawMode,
  input  logic [Digits-1:0]     Dp,
  input  logic [Digits-1:0]     Blank,
  input  logic [Digits-1:0]     Blink,
  input  logic [DimBits-1:0]    Brightness,
  output logic [Digits-1:0]     Indicators,
  output logic [7:0]            Segments,
  output logic                  FrameStart
);

  localparam int Prescale    = RefreshTime_ns / ClockPeriod_ns / Digits;
  localparam int SubPrescale = Prescale >> DimBits;
  // Keeps the prescaler legal while the elaboration error below fires.
  localparam int TickN       = (SubPrescale < 1) ? 1 : SubPrescale;
  localparam int DW          = $clog2(Digits);
  localparam int FW          = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;

  localparam logic [DW-1:0]      LAST_DIGIT = DW'(Digits - 1);
  localparam logic [DimBits-1:0] PHASE_MAX  = '1;
  localparam logic [FW-1:0]      FRAME_LAST = FW'(BlinkFrames - 1);

  if (SubPrescale < 1) begin : g_bad_timing
    $error("seg_scan_driver: refresh period too short for Digits/DimBits at this clock");
  end

  // Scan timebase
  logic               tick;
  logic [DimBits-1:0] sub_phase;
  logic [DW-1:0]      digit_idx;
  logic               phase_wrap;
  logic               frame_adv;

  // Frame snapshot
  logic [Digits*4-1:0] snap_nibbles;
  logic [Digits*8-1:0] snap_raw_seg;
  logic [Digits-1:0]   snap_raw_mode;
  logic [Digits-1:0]   snap_dp;
  logic [Digits-1:0]   snap_blank;
  logic [Digits-1:0]   snap_blink;
  logic [DimBits-1:0]  snap_bright;

  // Blink phase
  logic [FW-1:0] frame_cnt;
  logic          blink_off;

  // Current digit, selected out of the snapshot
  logic [3:0]        cur_nib;
  logic [7:0]        cur_raw;
  logic              cur_mode;
  logic              cur_dp;
  logic              cur_blank;
  logic              cur_blink;
  logic [7:0]        pattern;
  logic              lit;
  logic [Digits-1:0] select_low;

  SelectNPulse #(
    .N (TickN)
  ) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Pulse (tick)
  );

  assign phase_wrap = tick && (sub_phase == PHASE_MAX);
  // The advance that carries digit 0 back to the top digit starts a frame.
  assign frame_adv  = phase_wrap && (digit_idx == '0);

  // Sub-phase steps once per tick and wraps naturally.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sub_phase <= '0;
    end else if (tick) begin
      sub_phase <= sub_phase + 1'b1;
    end
  end

  // Digit index counts down from Digits-1 once per full slot.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      digit_idx <= LAST_DIGIT;
    end else if (phase_wrap) begin
      if (digit_idx == '0) begin
        digit_idx <= LAST_DIGIT;
      end else begin
        digit_idx <= digit_idx - 1'b1;
      end
    end
  end

  // Capture every display input at the frame boundary; reset leaves all digits blanked.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      snap_nibbles  <= '0;
      snap_raw_seg  <= '0;
      snap_raw_mode <= '0;
      snap_dp       <= '0;
      snap_blank    <= '1;
      snap_blink    <= '0;
      snap_bright   <= '0;
    end else if (frame_adv) begin
      snap_nibbles  <= Nibbles;
      snap_raw_seg  <= RawSeg;
      snap_raw_mode <= RawMode;
      snap_dp       <= Dp;
      snap_blank    <= Blank;
      snap_blink    <= Blink;
      snap_bright   <= Brightness;
    end
  end

  // Count snapshots; flip the blink phase each time the count wraps.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_adv) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Select the fields of the digit being scanned out of the snapshot.
  always_comb begin
    cur_nib   = '0;
    cur_raw   = SEG_BLANK;
    cur_mode  = 1'b0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_blink = 1'b0;
    for (int i = 0; i < Digits; i++) begin
      if (digit_idx == DW'(i)) begin
        cur_nib   = snap_nibbles[i*4 +: 4];
        cur_raw   = snap_raw_seg[i*8 +: 8];
        cur_mode  = snap_raw_mode[i];
        cur_dp    = snap_dp[i];
        cur_blank = snap_blank[i];
        cur_blink = snap_blink[i];
      end
    end
  end

  // Build the glyph and decide whether this sub-phase is lit.
  always_comb begin
    pattern = cur_mode ? cur_raw : hex7(cur_nib);
    if (cur_dp) begin
      pattern[DP_BIT] = 1'b0;
    end
    lit        = !cur_blank && !(cur_blink && blink_off) && (sub_phase <= snap_bright);
    select_low = ~(Digits'(1) << digit_idx);
  end

  // Register select, segments and frame pulse together so the digit and its
  // pattern always switch in the same Clock and select never goes multi-hot.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Indicators <= '1;
      Segments   <= SEG_BLANK;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= frame_adv;
      if (lit) begin
        Indicators <= select_low;
        Segments   <= pattern;
      end else begin
        Indicators <= '1;
        Segments   <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4 sub-phases of 4 Clocks,
// 16-Clock slots, 64-Clock frames. A reference model builds the expected
// {FrameStart, Indicators, Segments} stream for each frame when it takes its
// own snapshot, and every Clock one entry is popped and compared.
module tb_seg_scan_driver;

  localparam int Digits         = 4;
  localparam int DimBits        = 2;
  localparam int ClockPeriod_ns = 20;
  localparam int RefreshTime_ns = 1280;
  localparam int BlinkFrames    = 2;
  localparam int FrameLen       = 64;
  localparam int SlotLen        = 16;
  localparam int PhaseLen       = 4;

  logic                  Clock = 1'b0;
  logic                  Reset = 1'b1;
  logic [Digits*4-1:0]   Nibbles = '0;
  logic [Digits*8-1:0]   RawSeg = '0;
  logic [Digits-1:0]     RawMode = '0;
  logic [Digits-1:0]     Dp = '0;
  logic [Digits-1:0]     Blank = '0;
  logic [Digits-1:0]     Blink = '0;
  logic [DimBits-1:0]    Brightness = '0;
  logic [Digits-1:0]     Indicators;
  logic [7:0]            Segments;
  logic                  FrameStart;

  seg_scan_driver #(
    .Digits         (Digits),
    .ClockPeriod_ns (ClockPeriod_ns),
    .RefreshTime_ns (RefreshTime_ns),
    .DimBits        (DimBits),
    .BlinkFrames    (BlinkFrames)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Nibbles    (Nibbles),
    .RawSeg     (RawSeg),
    .RawMode    (RawMode),
    .Dp         (Dp),
    .Blank      (Blank),
    .Blink      (Blink),
    .Brightness (Brightness),
    .Indicators (Indicators),
    .Segments   (Segments),
    .FrameStart (FrameStart)
  );

  // ---------------- clock ----------------
  always #(ClockPeriod_ns / 2) Clock = ~Clock;

  // ---------------- scoreboard state ----------------
  logic [12:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference snapshot and blink phase
  logic [Digits*4-1:0] m_nib;
  logic [Digits*8-1:0] m_raw;
  logic [Digits-1:0]   m_mode;
  logic [Digits-1:0]   m_dp;
  logic [Digits-1:0]   m_blank;
  logic [Digits-1:0]   m_blink;
  logic [DimBits-1:0]  m_bright;
  int                  m_cnt;
  logic                m_boff;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      $error("%s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Expected output for position j (0..63) of a frame, from the model snapshot.
  function automatic logic [12:0] frame_entry(input int j);
    int         d;
    int         sp;
    logic       lit;
    logic [7:0] pat;
    logic [3:0] ind;
    d   = (Digits - 1) - (j / SlotLen);
    sp  = (j % SlotLen) / PhaseLen;
    pat = m_mode[d] ? m_raw[d*8 +: 8] : hex_tab[m_nib[d*4 +: 4]];
    if (m_dp[d]) pat[7] = 1'b0;
    lit = !m_blank[d] && !(m_blink[d] && m_boff) && (sp <= int'(m_bright));
    ind = 4'b0001 << d;
    ind = ~ind;
    if (!lit) begin
      ind = 4'hF;
      pat = 8'hFF;
    end
    return {(j == FrameLen - 1), ind, pat};
  endfunction

  task automatic push_frame();
    for (int j = 0; j < FrameLen; j++) exp_q.push_back(frame_entry(j));
  endtask

  task automatic model_reset();
    m_nib    = '0;
    m_raw    = '0;
    m_mode   = '0;
    m_dp     = '0;
    m_blank  = '1;
    m_blink  = '0;
    m_bright = '0;
    m_cnt    = 0;
    m_boff   = 1'b0;
    cyc      = 0;
    exp_q.delete();
    push_frame();
  endtask

  task automatic model_snapshot();
    m_nib    = Nibbles;
    m_raw    = RawSeg;
    m_mode   = RawMode;
    m_dp     = Dp;
    m_blank  = Blank;
    m_blink  = Blink;
    m_bright = Brightness;
    if (m_cnt == BlinkFrames - 1) begin
      m_cnt  = 0;
      m_boff = ~m_boff;
    end else begin
      m_cnt++;
    end
    push_frame();
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; each iteration samples the next cycle.
  task automatic run_cycles(input int n);
    logic [12:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      cyc++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty cyc=%0d observed=%h expected=none", cyc,
                 {FrameStart, Indicators, Segments});
      end else begin
        e = exp_q.pop_front();
        check("scan", {FrameStart, Indicators, Segments}, e);
      end
      if (cyc % FrameLen == 0) model_snapshot();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Held in reset: dark outputs, no frame pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("reset_hold", {FrameStart, Indicators, Segments}, {1'b0, 4'hF, 8'hFF});
    end

    // Release with 1A3F at full brightness: one dark frame, then 1,A,3,F.
    Nibbles    = 16'h1A3F;
    Brightness = 2'd3;
    Reset      = 1'b0;
    model_reset();
    run_cycles(3 * FrameLen);

    // Raw pattern on digit 0, decimal point on digit 1 showing 8.
    RawMode = 4'b0001;
    RawSeg  = 32'h0000_00AA;
    Dp      = 4'b0010;
    Nibbles = 16'h1A8F;
    run_cycles(2 * FrameLen);

    // Dimmest setting: one sub-phase lit per slot.
    Brightness = 2'd0;
    run_cycles(2 * FrameLen);

    // Snapshot coherence: change the value partway through a frame.
    RawMode    = '0;
    Dp         = '0;
    Brightness = 2'd3;
    Nibbles    = 16'h1111;
    run_cycles(FrameLen + 20);
    Nibbles    = 16'h2222;
    run_cycles(FrameLen - 20 + 2 * FrameLen);

    // Blink on digit 2, blank on digit 3 (blank wins in both phases).
    Blink = 4'b0100;
    Blank = 4'b1000;
    run_cycles(7 * FrameLen);

    // Asynchronous reset between edges, part way through a slot.
    run_cycles(21);
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset", {FrameStart, Indicators, Segments}, {1'b0, 4'hF, 8'hFF});
    @(negedge Clock);
    check("async_reset_hold", {FrameStart, Indicators, Segments}, {1'b0, 4'hF, 8'hFF});
    Blink   = '0;
    Blank   = 4'b0001;
    Nibbles = 16'h4567;
    Reset   = 1'b0;
    model_reset();
    run_cycles(3 * FrameLen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
